regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_arb_pkg.sv | 24 ++
 rtl/regfile_write_arbiter_rr_priority_pick.sv | 38 +++
 rtl/regfile_write_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_arb_pkg
// Brief    : Shared constants, FSM state type and index-width helper for the
//            register-file write arbiter.
// Revision : 1.0
// ============================================================================
package regfile_arb_pkg;

    localparam int NUM_REGS   = 8;
    localparam int REG_ADDR_W = 3;

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Width of an unpacked requester index; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_pick
// Brief    : Combinational round-robin pick: first set request searching from
//            last+1 (mod N), returned as one-hot grant and binary index.
// Revision : 1.0
// ============================================================================
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] w_j;

    // The owner at 'last' is reached on the final iteration, so it has lowest priority.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        w_j   = '0;
        for (int k = 1; k <= N; k++) begin
            w_j = IW'((int'(last) + k) % N);
            if (!any && req[w_j]) begin
                grant[w_j] = 1'b1;
                idx        = w_j;
                any        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Brief    : Round-robin arbiter with lockable bursts sharing one register-file
//            write port; registered output stage. Option: ZERO_REG_PROTECT_EN.
// Revision : 1.0
// ============================================================================
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = REG_ADDR_W,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        wr_stall,
    output logic                        wr_enable,
    output logic [ADDR_W-1:0]           wr_sel,
    output logic [DATA_W-1:0]           wr_data,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

    localparam int c_IW = idx_width(NUM_REQ);

    arb_state_t        r_state, w_state_nxt;
    logic [c_IW-1:0]   r_last, w_last_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt, w_cnt_inc;

    logic [NUM_REQ-1:0] w_pick_req, w_grant, w_owner_mask;
    logic [c_IW-1:0]    w_idx;
    logic               w_any, w_xfer, w_lock, w_wr_ok;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_data;

    // During a burst only the owner may be picked; the picker reaches it last.
    assign w_owner_mask = NUM_REQ'(1) << r_last;
    assign w_pick_req   = (r_state == BURST) ? (req_valid & w_owner_mask) : req_valid;

    rr_priority_pick #(
        .N  (NUM_REQ),
        .IW (c_IW)
    ) u_pick (
        .req   (w_pick_req),
        .last  (r_last),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    assign req_ready = (rst_n && !wr_stall && w_any) ? w_grant : '0;
    assign w_xfer    = |(req_valid & req_ready);
    assign w_lock    = req_lock[w_idx];
    assign w_addr    = req_addr[w_idx*ADDR_W +: ADDR_W];
    assign w_data    = req_data[w_idx*DATA_W +: DATA_W];
    assign w_cnt_inc = r_cnt + 4'd1;

`ifdef ZERO_REG_PROTECT_EN
    assign w_wr_ok = (w_addr != '0);
`else
    assign w_wr_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB;
            r_last  <= c_IW'(NUM_REQ - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        if (!wr_stall) begin
            case (r_state)
                ARB: begin
                    if (w_xfer) begin
                        w_last_nxt = w_idx;
                        if (w_lock && (MAX_BURST > 1)) begin
                            w_state_nxt = BURST;
                            w_cnt_nxt   = 4'd1;
                        end
                    end
                end
                BURST: begin
                    // Without stall, no transfer here means the owner dropped valid.
                    if (w_xfer && w_lock && (32'(w_cnt_inc) < MAX_BURST)) begin
                        w_cnt_nxt = w_cnt_inc;
                    end else begin
                        w_state_nxt = ARB;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ARB;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_enable <= 1'b0;
            wr_sel    <= '0;
            wr_data   <= '0;
            grant_id  <= '0;
        end else begin
            wr_enable <= w_xfer && w_wr_ok;
            if (w_xfer) begin
                wr_sel   <= w_addr;
                wr_data  <= w_data;
                grant_id <= w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Brief    : Directed self-checking bench for regfile_write_arbiter (4 req).
// Revision : 1.0
// ============================================================================
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_lock;
    logic [11:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        wr_stall;
    logic        wr_enable;
    logic [2:0]  wr_sel;
    logic [7:0]  wr_data;
    logic [1:0]  grant_id;

    int total = 0;
    int bad   = 0;

    regfile_write_arbiter #(
        .NUM_REQ   (4),
        .ADDR_W    (3),
        .DATA_W    (8),
        .MAX_BURST (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_stall  (wr_stall),
        .wr_enable (wr_enable),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Default requester payload: addr = i+1, data = 8'hC0+i.
    task automatic load_default_payload();
        for (int i = 0; i < 4; i++) begin
            req_addr[i*3 +: 3] = 3'(i + 1);
            req_data[i*8 +: 8] = 8'hC0 + 8'(i);
        end
    endtask

    // Called at posedge+1 with inputs driven: checks the grant, then the write.
    task automatic expect_grant(input string tag, input int idx);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(oh));
        @(posedge clk); #1;
        check({tag, "_wen"}, 32'(wr_enable), 32'd1);
        check({tag, "_gid"}, 32'(grant_id), 32'(idx));
        check({tag, "_sel"}, 32'(wr_sel), 32'(idx + 1));
        check({tag, "_data"}, 32'(wr_data), 32'(8'hC0 + 8'(idx)));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_lock  = '0;
        wr_stall  = 1'b0;
        load_default_payload();
        req_addr[2:0] = 3'd5;
        req_data[7:0] = 8'hA5;

        // Reset state, with requests pending while reset is held
        req_valid = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_wen", 32'(wr_enable), 32'd0);
        check("rst_sel", 32'(wr_sel), 32'd0);
        check("rst_data", 32'(wr_data), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        req_valid = '0;
        rst_n = 1'b1;

        // Single write from requester 0
        @(posedge clk); #1;
        req_valid = 4'b0001;
        #1 check("single_ready", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        check("single_wen", 32'(wr_enable), 32'd1);
        check("single_sel", 32'(wr_sel), 32'd5);
        check("single_data", 32'(wr_data), 32'hA5);
        check("single_gid", 32'(grant_id), 32'd0);
        @(posedge clk); #1;
        check("single_wen_off", 32'(wr_enable), 32'd0);
        check("single_sel_hold", 32'(wr_sel), 32'd5);

        // Plain rotation from reset
        load_default_payload();
        do_reset();
        @(posedge clk); #1;
        req_valid = 4'b1111;
        for (int n = 0; n < 8; n++) expect_grant($sformatf("rr%0d", n), n % 4);

        // Move pointer to 1, then burst by requester 2
        req_valid = 4'b0011;
        expect_grant("pre0", 0);
        expect_grant("pre1", 1);
        req_valid = 4'b1111;
        req_lock  = 4'b0100;
        expect_grant("bst0", 2);
        expect_grant("bst1", 2);
        expect_grant("bst2", 2);
        expect_grant("bst3", 2);
        expect_grant("bst4", 3);
        expect_grant("bst5", 0);
        expect_grant("bst6", 1);
        expect_grant("bst7", 2);
        // Owner drops valid: burst ends, no write
        req_lock  = '0;
        req_valid = '0;
        #1 check("drop_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("drop_wen", 32'(wr_enable), 32'd0);

        // Stall for three cycles, pointer stays at 2
        req_valid = 4'b1111;
        wr_stall  = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1 check($sformatf("stall%0d_ready", n), 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            check($sformatf("stall%0d_wen", n), 32'(wr_enable), 32'd0);
        end
        wr_stall = 1'b0;
        expect_grant("unstall0", 3);
        expect_grant("unstall1", 0);

        // Reset asserted the cycle after a transfer
        req_valid = 4'b0010;
        expect_grant("pre_rst", 1);
        req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        check("midrst_wen", 32'(wr_enable), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("postrst_ready", 32'(req_ready), 32'b0001);

        // Write to register 0
        @(posedge clk); #1;
        req_valid = 4'b0001;
        req_addr[2:0] = 3'd0;
        req_data[7:0] = 8'hFF;
        #1 check("zero_ready", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
`ifdef ZERO_REG_PROTECT_EN
        check("zero_wen", 32'(wr_enable), 32'd0);
`else
        check("zero_wen", 32'(wr_enable), 32'd1);
`endif
        check("zero_sel", 32'(wr_sel), 32'd0);
        check("zero_data", 32'(wr_data), 32'hFF);
        check("zero_gid", 32'(grant_id), 32'd0);
        load_default_payload();
        req_valid = 4'b1111;
        expect_grant("after_zero", 1);

        req_valid = '0;
        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
